serial_tx_sched: RTL

Two-requester scheduler and sequencer for a shared parallel-to-serial shift register (width FRAME_BITS, MSB shifted first, fills with 1s, resets to all 1s).
- Round-robin arbitration between two word sources.
- Builds an asynchronous-serial frame: start 0, data MSB first, optional parity, stop 1.
- Pulses the register's load and shift controls at the configured bit rate.
- Sits between packet logic and the serial line driver; the line idles high.

---
 rtl/serial_tx_pkg.sv | 37 +++
 rtl/serial_tx_sched_bit_timer.sv | 27 ++
 rtl/serial_tx_sched.sv | 92 +++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and frame packing for the serial transmit scheduler.
// TX_PARITY_EN adds an even-parity bit between the data and the stop bit.
package serial_tx_pkg;

  typedef enum logic {IDLE, SHIFT} tx_state_t;

`ifdef TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int MAX_DATA_BITS  = 64;
  localparam int MAX_FRAME_BITS = MAX_DATA_BITS + 3;
  localparam int DATA_IDX_W     = $clog2(MAX_DATA_BITS);
  localparam int FRAME_IDX_W    = $clog2(MAX_FRAME_BITS);

  // Right-aligned frame: start 0, data MSB first, optional parity, stop 1.
  // Bits above the frame stay 1 so a truncation keeps only the frame.
  function automatic logic [MAX_FRAME_BITS-1:0] build_frame(
    input logic [MAX_DATA_BITS-1:0] data,
    input int                       data_bits
  );
    logic [MAX_FRAME_BITS-1:0] f;
    f = '1;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < data_bits)
        f[FRAME_IDX_W'(1 + PARITY_BITS + i)] = data[DATA_IDX_W'(i)];
    end
`ifdef TX_PARITY_EN
    f[1] = ^data;
`endif
    f[FRAME_IDX_W'(1 + PARITY_BITS + data_bits)] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/serial_tx_sched_bit_timer.sv
// Reloadable bit-period down-counter; tick marks the last clock of a bit.
module serial_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic run,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign tick = run && (count == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count <= '0;
    else if (load || tick)
      count <= RELOAD;
    else if (run)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/serial_tx_sched.sv
// Two-requester round-robin scheduler driving a parallel-to-serial shift register.
// Build option TX_PARITY_EN inserts an even-parity bit into every frame.
module serial_tx_sched
  import serial_tx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  localparam int FRAME_BITS  = DATA_BITS + 2 + PARITY_BITS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [1:0]            req_valid,
  input  logic [DATA_BITS-1:0]  req_data0,
  input  logic [DATA_BITS-1:0]  req_data1,
  output logic [1:0]            req_ready,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  busy,
  output logic                  grant_id
);
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(FRAME_BITS - 1);

  tx_state_t        state, state_nxt;
  logic             last_grant;
  logic             winner;
  logic             tick;
  logic [CNT_W-1:0] bit_cnt;

  serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .n_rst(n_rst),
    .load (load_enable),
    .run  (state == SHIFT),
    .tick (tick)
  );

  // Strobes are held low while reset is asserted so no handshake slips through.
  always_comb begin
    state_nxt    = state;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    req_ready    = 2'b00;
    frame_out    = '1;
    winner       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    if (n_rst) begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            load_enable       = 1'b1;
            req_ready[winner] = 1'b1;
            frame_out = FRAME_BITS'(build_frame(
              MAX_DATA_BITS'(winner ? req_data1 : req_data0), DATA_BITS));
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            shift_enable = 1'b1;
            if (bit_cnt == LAST_SHIFT)
              state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SHIFT);
      if (load_enable) begin
        last_grant <= winner;
        grant_id   <= winner;
        bit_cnt    <= '0;
      end else if (shift_enable) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule
